// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and flush controller for the 5-stage RISC-V pipeline.
//
// Sits opposite the D/E pipeline register. It drives:
//   - StallF / StallD : hold the PC and the F/D register on a load-use hazard
//   - FlushD          : clear the F/D register on a taken branch/jump
//   - FlushE          : Clr of the D/E register (load-use bubble or branch)
//   - ForwardAE/BE    : E-stage ALU operand selects (00 RF, 10 M, 01 W)
//   - StallCnt        : saturating count of cycles with StallF high
//   - FlushCnt        : saturating count of cycles with PCSrcE high
//
// Inputs: D-stage sources (Rs1D/Rs2D), the E-stage fields of the D/E register
// (Rs1E/Rs2E/RdE/ResultSrcE), M/W write-back info and PCSrcE.
//
// Load-use stalls are counter-driven. The first bubble clears the D/E
// register, so RdE reads 0 from then on and cannot keep the stall alive.
// The counter supplies the remaining LOAD_BUBBLES-1 bubbles instead.
// While rst is low, every output is forced inactive.

// One forwarding-select unit per E-stage source operand.
module hazard_fwd (
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (we_m && rd_m != 5'd0 && rd_m == rs_e)      fwd = 2'b10;  // M is younger, wins
    else if (we_w && rd_w != 5'd0 && rd_w == rs_e) fwd = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,   // 1..7 bubbles per load-use hazard
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,        // async, active-low
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  localparam int        NUM_OPS  = 2;
  localparam logic [2:0] BUB_INIT = 3'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {RUN, STALL} state_t;

  // ---------------- forwarding ----------------
  logic [NUM_OPS-1:0][4:0] rs_e;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign rs_e = {Rs2E, Rs1E};

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_fwd
    hazard_fwd u_fwd (
      .rs_e (rs_e[gi]),
      .rd_m (RdM),
      .we_m (RegWriteM),
      .rd_w (RdW),
      .we_w (RegWriteW),
      .fwd  (fwd[gi])
    );
  end

  assign ForwardAE = rst ? fwd[0] : 2'b00;
  assign ForwardBE = rst ? fwd[1] : 2'b00;

  // ---------------- load-use FSM ----------------
  logic   lw_haz;
  state_t state_q, state_d;
  logic [2:0] bub_q, bub_d;
  logic   stall, flush_d, flush_e;

  assign lw_haz = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (PCSrcE) begin
      // Redirect squashes the stalled instruction too; no bubbles remain.
      flush_d = 1'b1;
      flush_e = 1'b1;
      state_d = RUN;
      bub_d   = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (lw_haz) begin
            stall   = 1'b1;
            flush_e = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = STALL;
              bub_d   = BUB_INIT;
            end
          end
        end
        STALL: begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (bub_q == 3'd1) begin
            state_d = RUN;
            bub_d   = 3'd0;
          end else begin
            bub_d   = bub_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          bub_d   = 3'd0;
        end
      endcase
    end
  end

  assign StallF = rst & stall;
  assign StallD = rst & stall;
  assign FlushD = rst & flush_d;
  assign FlushE = rst & flush_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      bub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // ---------------- performance counters ----------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (PCSrcE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and flush controller for the 5-stage pipelined RISC-V core.
- Sits opposite the D/E pipeline register. It consumes that register's E-stage outputs (Rs1E, Rs2E, RdE, ResultSrcE) and drives the Clr (FlushE) that empties it.
- Also drives fetch/decode stalls, the D-stage flush, and the E-stage forwarding selects.
- Holds a counter-based load-use stall FSM, because RdE reads 0 after the first bubble. Also holds saturating stall/flush performance counters.

Parameters:
LOAD_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7)
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
Rs1D  input  5  source reg 1 of instruction in D
Rs2D  input  5  source reg 2 of instruction in D
Rs1E  input  5  source reg 1 in E (from D/E register)
Rs2E  input  5  source reg 2 in E
RdE  input  5  destination reg in E
ResultSrcE  input  2  result select in E; 2'b01 = load
RdM  input  5  destination reg in M
RegWriteM  input  1  M-stage register write enable
RdW  input  5  destination reg in W
RegWriteW  input  1  W-stage register write enable
PCSrcE  input  1  taken branch/jump resolved in E
StallF  output  1  hold PC
StallD  output  1  hold F/D register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register (drives its Clr)
ForwardAE  output  2  ALU operand A select: 00 reg file, 10 from M, 01 from W
ForwardBE  output  2  ALU operand B select, same encoding
StallCnt  output  CNT_W  stall cycles counted
FlushCnt  output  CNT_W  branch flush events counted

Behaviour:
- Reset (rst=0, async):
  - FSM goes to RUN; bubble counter = 0.
  - StallCnt = FlushCnt = 0.
  - Outputs held inactive while reset is asserted: all stall/flush = 0, Forward* = 00.
- Forwarding is combinational and independent of the FSM:
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00. M beats W.
  - ForwardBE uses the same rule on Rs2E.
- lwHaz (combinational) = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, STALL. The bubble counter is 3 bits.
  - RUN, lwHaz=1, PCSrcE=0:
    - Same cycle: StallF=StallD=FlushE=1.
    - If LOAD_BUBBLES>1, next state STALL with counter=LOAD_BUBBLES-1; otherwise stay RUN.
  - STALL:
    - StallF=StallD=FlushE=1 regardless of lwHaz.
    - Counter decrements each cycle; return to RUN in the cycle after it reads 1.
    - Total bubbles per hazard = LOAD_BUBBLES exactly.
  - RUN, no hazard: all stall/flush = 0.
- PCSrcE=1 (any state):
  - FlushD=FlushE=1, StallF=StallD=0.
  - Next state RUN, counter cleared.
  - Priority: PCSrcE over load-use stall in the same cycle.
- StallCnt: +1 on every clock edge where StallF=1. Saturates at all-ones.
- FlushCnt: +1 on every edge where PCSrcE=1. Saturates at all-ones.
- Reset mid-STALL: immediate return to RUN; counters cleared; no residual bubbles after release.
- x0 never creates a hazard or forwarding.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=5 -> ForwardAE=ForwardBE=10. Then RegWriteM=0 -> both 01. Then RdM=RdW=0 -> both 00.
- Load-use, LOAD_BUBBLES=1: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCnt=1. With RdE=0 -> no stall.
- LOAD_BUBBLES=3: same stimulus, then RdE=0 from the next cycle -> stall/FlushE held for exactly 3 cycles; StallCnt=3; FSM back in RUN.
- Branch flush: PCSrcE=1 for 1 cycle -> FlushD=FlushE=1, StallF=0; FlushCnt=1. PCSrcE and lwHaz together -> flush wins, StallF=0, no STALL entry.
- Reset: assert rst=0 during the second bubble of a LOAD_BUBBLES=3 stall -> outputs 0 immediately, counters 0. After release with no hazard, StallF stays 0.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> StallCnt=15 and stays 15.
